// File: rtl/parity_receive_fifo.sv
// Parity-checked receive stage that feeds a DEPTH-entry show-ahead FIFO.
// Optional: define RECEIVE_PASS_BAD_EN to forward bad words flagged on out_err instead of dropping them.
module parity_receive_fifo #(
  parameter int DATA_W     = 9,
  parameter int DEPTH      = 4,
  parameter int PARITY_ODD = 0,
  parameter int ERR_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W:0]          in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
`ifdef RECEIVE_PASS_BAD_EN
  output logic                     out_err,
`endif
  output logic                     parity_err,
  output logic [ERR_W-1:0]         err_count,
  input  logic                     err_clr,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef RECEIVE_PASS_BAD_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(DEPTH);

  // Stage-1 register
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W:0]   s1_data_q, s1_data_d;

  // FIFO state
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Error reporting
  logic              parity_err_q, parity_err_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  logic               s1_ok;
  logic               s1_bad;
  logic               accept;
  logic               push;
  logic               pop;
  logic [CNT_W:0]     occupancy;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

  // Parity reduction spans the data bits and the parity bit together.
  assign s1_ok  = (PARITY_ODD != 0) ? ^s1_data_q : ~^s1_data_q;
  assign s1_bad = s1_valid_q && !s1_ok;

  // Occupancy counts the word waiting in stage 1 so a full FIFO can never be pushed.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q};
  assign in_ready  = occupancy < OCC_LIMIT;
  assign accept    = in_valid && in_ready;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head[DATA_W-1:0];

`ifdef RECEIVE_PASS_BAD_EN
  assign push     = s1_valid_q;
  assign wr_entry = {!s1_ok, s1_data_q[DATA_W-1:0]};
  assign out_err  = head[DATA_W];
`else
  assign push     = s1_valid_q && s1_ok;
  assign wr_entry = s1_data_q[DATA_W-1:0];
`endif

  assign parity_err = parity_err_q;
  assign err_count  = err_count_q;
  assign fifo_count = count_q;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    s1_valid_d   = accept;
    s1_data_d    = accept ? in_data : s1_data_q;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    parity_err_d = s1_bad;
    err_count_d  = err_count_q;
    // A clear coinciding with a new error wins; the error still pulses parity_err.
    if (err_clr) begin
      err_count_d = '0;
    end else if (s1_bad && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      parity_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      parity_err_q <= parity_err_d;
      err_count_q  <= err_count_d;
    end
  end

  // NOTE: storage is not reset; the reset pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_parity_receive_fifo.sv
// Randomized scoreboard bench for parity_receive_fifo; honours RECEIVE_PASS_BAD_EN like the design.
module tb_parity_receive_fifo;

  localparam int DATA_W     = 9;
  localparam int DEPTH      = 4;
  localparam int PARITY_ODD = 0;
  localparam int ERR_W      = 2;
  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W:0]   in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              parity_err;
  logic [ERR_W-1:0]  err_count;
  logic              err_clr;
  logic [CNT_W-1:0]  fifo_count;
`ifdef RECEIVE_PASS_BAD_EN
  logic              out_err;
`endif

  parity_receive_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PARITY_ODD(PARITY_ODD), .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
`ifdef RECEIVE_PASS_BAD_EN
    .out_err(out_err),
`endif
    .parity_err(parity_err),
    .err_count(err_count),
    .err_clr(err_clr),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A word is good when its total count of ones has the parity selected by PARITY_ODD.
  function automatic bit is_good(input logic [DATA_W:0] w);
    return ($countones(w) % 2) == PARITY_ODD;
  endfunction

  function automatic logic [DATA_W:0] mk(input logic [DATA_W-1:0] d, input bit good);
    bit p;
    p = (($countones(d) % 2) != PARITY_ODD);
    if (!good) p = !p;
    return {p, d};
  endfunction

  // Behavioural reference: a queue of stored words, the word in flight, and the error tally.
  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          fifo_q[$];
  bit              s1_v      = 1'b0;
  logic [DATA_W:0] s1_w      = '0;
  bit              exp_perr  = 1'b0;
  int              model_cnt = 0;

  always @(negedge clk) begin
    bit     exp_ready;
    bit     err_now;
    bit     acc;
    entry_t e;
    exp_ready = (fifo_q.size() + (s1_v ? 1 : 0)) < DEPTH;
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, fifo_q.size() != 0);
    check("fifo_count", fifo_count, fifo_q.size());
    check("fifo_count_bound", fifo_count <= DEPTH, 1);
    if (fifo_count == DEPTH) check("full_blocks_in_ready", in_ready, 0);
    check("parity_err", parity_err, exp_perr);
    check("err_count", err_count, model_cnt);
    if (fifo_q.size() != 0) begin
      check("out_data", out_data, fifo_q[0].data);
`ifdef RECEIVE_PASS_BAD_EN
      check("out_err", out_err, fifo_q[0].err);
`endif
    end

    // Advance the model to what the DUT should show after the coming edge.
    if (!rst_n) begin
      fifo_q.delete();
      s1_v      = 1'b0;
      exp_perr  = 1'b0;
      model_cnt = 0;
    end else begin
      err_now  = s1_v && !is_good(s1_w);
      exp_perr = err_now;
      if (err_clr) model_cnt = 0;
      else if (err_now && model_cnt != ERR_MAX) model_cnt++;
      if (fifo_q.size() != 0 && out_ready) void'(fifo_q.pop_front());
      if (s1_v) begin
        e.err  = !is_good(s1_w);
        e.data = s1_w[DATA_W-1:0];
`ifdef RECEIVE_PASS_BAD_EN
        fifo_q.push_back(e);
`else
        if (!e.err) fifo_q.push_back(e);
`endif
      end
      acc  = in_valid && exp_ready;
      s1_v = acc;
      if (acc) s1_w = in_data;
    end
  end

  task automatic cyc(input bit v, input logic [DATA_W:0] d, input bit ordy,
                     input bit clr, input bit rstn);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    err_clr   = clr;
    rst_n     = rstn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset held for two edges while upstream offers a word.
    repeat (2) cyc(1'b1, mk(9'h0AA, 1'b1), 1'b1, 1'b0, 1'b0);
    idle(2);

    // Two good words back to back.
    cyc(1'b1, {1'b0, 9'h0AA}, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, {1'b1, 9'h155}, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Single parity error.
    cyc(1'b1, {1'b0, 9'h001}, 1'b1, 1'b0, 1'b1);
    idle(3);

    // Back-pressure fills the FIFO, then release with in_valid held.
    for (int i = 0; i < 8; i++) cyc(1'b1, mk(DATA_W'($urandom), 1'b1), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, mk(DATA_W'($urandom), 1'b1), 1'b1, 1'b0, 1'b1);
    idle(4);

    // Counter saturation, then a clear on the same edge as a sixth error is checked.
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(DATA_W'($urandom), 1'b0), 1'b1, 1'b0, 1'b1);
    idle(2);
    cyc(1'b1, mk(DATA_W'($urandom), 1'b0), 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1);
    idle(3);

    // Bad word followed by a good one.
    cyc(1'b1, {1'b0, 9'h001}, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, {1'b0, 9'h003}, 1'b1, 1'b0, 1'b1);
    idle(4);

    // Random traffic with back-pressure, clears and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0,
          mk(DATA_W'($urandom), ($urandom % 5) != 0),
          ($urandom % 3) != 0,
          ($urandom % 40) == 0,
          ($urandom % 200) != 0);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parity_receive_fifo.md
Name: parity_receive_fifo

Overview:
Parametrised successor to the team's 10-bit parity-checked receiver.
- Accepts DATA_W data bits plus one parity bit per word over a valid/ready handshake, registers the word and checks parity in a selectable mode.
- Good words are buffered in a DEPTH-entry show-ahead FIFO; bad words are dropped and counted.
- Sits between the link transmitter and the downstream consumer, absorbing consumer back-pressure.

Parameters:
DATA_W, 9, payload width; parity bit sits at in_data[DATA_W].
DEPTH, 4, FIFO entries; power of 2, at least 2.
PARITY_ODD, 0, 0 = even parity (total ones across data and parity even), 1 = odd parity.
ERR_W, 8, width of the saturating parity-error counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
in_valid  input  1  upstream word present.
in_data  input  DATA_W+1  {parity, data[DATA_W-1:0]}.
in_ready  output  1  block can accept a word this cycle.
out_valid  output  1  FIFO head valid.
out_data  output  DATA_W  FIFO head payload.
out_ready  input  1  downstream accepts the head.
parity_err  output  1  one-cycle pulse when a word fails its parity check.
err_count  output  ERR_W  parity failures since reset or clear; saturates at all-ones.
err_clr  input  1  synchronous clear of err_count.
fifo_count  output  clog2(DEPTH)+1  number of words stored in the FIFO.

Behaviour:
Reset and handshake
- Reset (rst_n=0 at a clk edge): s1_valid=0, FIFO empty, pointers=0, out_valid=0, parity_err=0, err_count=0, fifo_count=0. out_data is don't-care while out_valid=0.
- Reset mid-operation discards the stage-1 word and all buffered words.
- Accept: in_valid && in_ready at edge k loads in_data into the stage-1 register; s1_valid=1.
- in_ready = (fifo_count + s1_valid) < DEPTH. It is driven from registers only, with no combinational path from out_ready or in_valid.

Check stage
- Stage 1 evaluates ok = ~^s1_data when PARITY_ODD=0, ok = ^s1_data when PARITY_ODD=1. Reduction covers all DATA_W+1 bits.
- At edge k+1 with ok=1: push s1_data[DATA_W-1:0] into the FIFO.
- At edge k+1 with ok=0: drop the word, parity_err=1 for one cycle, err_count increments unless it is all-ones.
- s1_valid clears at edge k+1 unless a new word is accepted at the same edge.
- Latency: a good word is accepted at edge k and shows out_valid=1 with its data in the cycle after edge k+1, i.e. 2 edges.
- Throughput: 1 word per cycle when not back-pressured.

FIFO
- Show-ahead: out_data = mem[rd_ptr]; out_valid = (fifo_count != 0).
- Pop on out_valid && out_ready.
- Simultaneous push and pop: fifo_count unchanged, both pointers advance.
- Push when fifo_count==DEPTH cannot occur by construction of in_ready; the bench asserts this.
- Pointers wrap modulo DEPTH.

Error counter
- err_clr and an error at the same edge: the clear wins and err_count=0. That error still pulses parity_err.
- err_count holds at 2^ERR_W-1 on further errors.

Optional Feature:
Macro RECEIVE_PASS_BAD_EN.
- Defined:
  - Bad words are pushed into the FIFO instead of dropped.
  - Each FIFO entry stores an extra flag bit, exposed on an added output port out_err (1 bit, valid with out_valid).
  - parity_err and err_count behave as in the base block.
  - in_ready is unchanged.
- Undefined: bad words are dropped, and the out_err port and flag storage do not exist.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, fifo_count=0, err_count=0, no push; after release in_ready=1.
2. Even parity stream (defaults): send 0x0AA with parity 0, then 0x155 with parity 1, out_ready=1 -> out_data 0x0AA then 0x155, each 2 edges after acceptance; parity_err stays 0.
3. Parity error: send 0x001 with parity 0 -> no push, parity_err pulses one cycle, err_count=1. With PARITY_ODD=1 the same word is accepted and 0x0AA with parity 0 is rejected.
4. Back-pressure: out_ready=0 and continuous good words -> exactly DEPTH (4) words stored, in_ready=0, fifo_count=4. Raise out_ready with in_valid held -> data in order, no loss, steady 1 word/cycle with simultaneous push/pop.
5. Saturation and clear: ERR_W=2, inject 5 bad words -> err_count sticks at 3. Assert err_clr on the same edge as a 6th error -> err_count=0 and parity_err pulses.
6. RECEIVE_PASS_BAD_EN defined: bad 0x001 with parity 0 followed by good 0x003 with parity 0 -> FIFO delivers 0x001 with out_err=1, then 0x003 with out_err=0.
